// File: rtl/zbus_bridge.sv
// zbus_bridge: ZX-bus to peripheral-bus bridge.
//   Filters the asynchronous Z80 IORQ/RD/WR strobes, and on a clean I/O read or
//   write start runs one timed peripheral cycle (SETUP -> STROBE -> HOLD) on the
//   channel selected by ch_req.
// Ports:
//   fclk, zrst_n                 - system clock, async active-low reset
//   ziorq_n, zrd_n, zwr_n, za    - Z80 I/O strobes and address (async)
//   zd_in / zd_out, zd_oe        - Z80 data in, read latch out, output enable
//   ch_req                       - per-channel address decode from upstream
//   cs_n, baddr                  - one-hot active-low chip selects, peripheral address
//   bd_in / bd_out, bd_oe        - peripheral data in, write latch out, output enable
//   brd_n, bwr_n                 - peripheral read / write strobes
//   busy                         - high while a peripheral cycle is in progress
module zbus_bridge #(
  parameter int NCH       = 2,
  parameter int AW        = 10,
  parameter int FILT      = 3,
  parameter int SETUP_CYC = 1,
  parameter int STB_CYC   = 4,
  parameter int HOLD_CYC  = 1
) (
  input  logic            fclk,
  input  logic            zrst_n,
  input  logic            ziorq_n,
  input  logic            zrd_n,
  input  logic            zwr_n,
  input  logic [AW-1:0]   za,
  input  logic [7:0]      zd_in,
  output logic [7:0]      zd_out,
  output logic            zd_oe,
  input  logic [NCH-1:0]  ch_req,
  output logic [NCH-1:0]  cs_n,
  output logic [AW-1:0]   baddr,
  input  logic [7:0]      bd_in,
  output logic [7:0]      bd_out,
  output logic            bd_oe,
  output logic            brd_n,
  output logic            bwr_n,
  output logic            busy
);

  // Counter wide enough for the largest phase length (STB_CYC up to 15).
  localparam int CW = 4;
  localparam logic [CW-1:0] L_SETUP = CW'((SETUP_CYC > 0) ? SETUP_CYC - 1 : 0);
  localparam logic [CW-1:0] L_STB   = CW'(STB_CYC - 1);
  localparam logic [CW-1:0] L_HOLD  = CW'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_t;

  logic [1:0]     r_rst_sync;
  logic           w_rst_n;
  logic [FILT-1:0] r_wr_f, r_rd_f;
  logic           w_wr_s, w_rd_s, w_wr_start, w_rd_start, w_start;
  logic [NCH-1:0] w_ch_low, w_ch_nxt;
  logic           w_dir_nxt, w_lat_rd, w_active_nxt;
  state_t         r_state, w_state_nxt;
  logic [CW-1:0]  r_cnt, w_cnt_nxt;
  logic [NCH-1:0] r_ch, r_cs_n;
  logic           r_dir, r_brd_n, r_bwr_n, r_bd_oe;
  logic [AW-1:0]  r_baddr;
  logic [7:0]     r_bd_out, r_rd_lat;

  // Reset asserts asynchronously but is released on a clock edge so that no
  // flop sees the release near an edge.
  always_ff @(posedge fclk or negedge zrst_n) begin
    if (!zrst_n) r_rst_sync <= '0;
    else         r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  // Strobe filters: the first stage of each shift register also serves as the
  // synchroniser for the asynchronous Z80 strobes.
  assign w_wr_s = ~(zwr_n | ziorq_n);
  assign w_rd_s = ~(zrd_n | ziorq_n);

  always_ff @(posedge fclk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_wr_f <= '0;
      r_rd_f <= '0;
    end else begin
      r_wr_f <= {r_wr_f[FILT-2:0], w_wr_s};
      r_rd_f <= {r_rd_f[FILT-2:0], w_rd_s};
    end
  end

  // A start is a 0 in the oldest sample followed by FILT-1 consecutive 1s, so
  // it fires once per edge and never on a shorter glitch.
  assign w_wr_start = ~r_wr_f[FILT-1] & (&r_wr_f[FILT-2:0]);
  assign w_rd_start = ~r_rd_f[FILT-1] & (&r_rd_f[FILT-2:0]);
  assign w_start    = (w_wr_start | w_rd_start) & (|ch_req) & (r_state == S_IDLE);

  // Isolate the lowest set request bit (two's-complement trick).
  assign w_ch_low = ch_req & (~ch_req + NCH'(1));

  always_ff @(posedge fclk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_lat_rd    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          if (SETUP_CYC > 0) begin
            w_state_nxt = S_SETUP;
            w_cnt_nxt   = L_SETUP;
          end else begin
            w_state_nxt = S_STROBE;
            w_cnt_nxt   = L_STB;
          end
        end
      end
      S_SETUP: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_STROBE;
          w_cnt_nxt   = L_STB;
        end else begin
          w_cnt_nxt   = r_cnt - CW'(1);
        end
      end
      S_STROBE: begin
        if (r_cnt == '0) begin
          // Last strobe cycle: the read data is latched on the edge that
          // raises brd_n.
          w_lat_rd = ~r_dir;
          if (HOLD_CYC > 0) begin
            w_state_nxt = S_HOLD;
            w_cnt_nxt   = L_HOLD;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt   = r_cnt - CW'(1);
        end
      end
      S_HOLD: begin
        if (r_cnt == '0) w_state_nxt = S_IDLE;
        else             w_cnt_nxt   = r_cnt - CW'(1);
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so that they come straight out of
  // flops and change on the same edge as the state.
  assign w_ch_nxt     = w_start ? w_ch_low   : r_ch;
  assign w_dir_nxt    = w_start ? w_wr_start : r_dir;
  assign w_active_nxt = (w_state_nxt != S_IDLE);

  always_ff @(posedge fclk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_ch     <= '0;
      r_dir    <= 1'b0;
      r_cs_n   <= '1;
      r_brd_n  <= 1'b1;
      r_bwr_n  <= 1'b1;
      r_bd_oe  <= 1'b0;
      r_baddr  <= '0;
      r_bd_out <= '0;
      r_rd_lat <= '0;
    end else begin
      r_ch    <= w_ch_nxt;
      r_dir   <= w_dir_nxt;
      r_cs_n  <= w_active_nxt ? ~w_ch_nxt : '1;
      r_brd_n <= ~((w_state_nxt == S_STROBE) & ~w_dir_nxt);
      r_bwr_n <= ~((w_state_nxt == S_STROBE) &  w_dir_nxt);
      r_bd_oe <= w_active_nxt & w_dir_nxt;
      if (w_start) begin
        r_baddr <= za;
        if (w_wr_start) r_bd_out <= zd_in;
      end
      if (w_lat_rd) r_rd_lat <= bd_in;
    end
  end

  assign cs_n   = r_cs_n;
  assign brd_n  = r_brd_n;
  assign bwr_n  = r_bwr_n;
  assign bd_oe  = r_bd_oe;
  assign baddr  = r_baddr;
  assign bd_out = r_bd_out;
  assign busy   = (r_state != S_IDLE);
  assign zd_out = r_rd_lat;
  assign zd_oe  = ~ziorq_n & ~zrd_n & (|ch_req);

endmodule

// File: doc/zbus_bridge.md
Name: zbus_bridge

Overview:
- Parametrised ZX-bus to peripheral-bus bridge. Successor to the single-timing, two-chip strobe buffer.
- Converts filtered Z80 I/O read/write cycles into timed peripheral cycles. Each cycle has programmable setup, strobe and hold phases.
- Drives NCH one-hot chip selects, a registered address and registered read/write data latches.
- Sits between the ZX-bus pins and the USB/Ethernet/extension chips. Address decoding stays upstream; the bridge receives per-channel request lines.

Parameters:
- NCH, 2, number of peripheral channels (1..8)
- AW, 10, width of the peripheral address bus
- FILT, 3, strobe synchroniser/filter depth in fclk samples (2..6)
- SETUP_CYC, 1, cycles with CS low and strobes high before the strobe (0..7)
- STB_CYC, 4, cycles the strobe is held low (1..15)
- HOLD_CYC, 1, cycles with CS still low after the strobe rises (0..7)

Ports:
- fclk  in  1  system clock
- zrst_n  in  1  asynchronous active-low reset
- ziorq_n  in  1  Z80 IORQ, async
- zrd_n  in  1  Z80 RD, async
- zwr_n  in  1  Z80 WR, async
- za  in  AW  Z80 address bits forwarded to the peripheral, async
- zd_in  in  8  Z80 data bus input
- zd_out  out  8  data to the Z80 (read latch)
- zd_oe  out  1  Z80 data bus output enable
- ch_req  in  NCH  async per-channel decode (1 = this I/O address belongs to channel i)
- cs_n  out  NCH  peripheral chip selects, active low
- baddr  out  AW  registered peripheral address
- bd_in  in  8  peripheral data bus input
- bd_out  out  8  write latch to the peripheral
- bd_oe  out  1  peripheral data bus output enable
- brd_n  out  1  peripheral read strobe
- bwr_n  out  1  peripheral write strobe
- busy  out  1  1 while the FSM is not in IDLE

Behaviour:
- Reset (zrst_n low, async):
  - cs_n all 1, brd_n=1, bwr_n=1, bd_oe=0, busy=0.
  - baddr=0, bd_out=0, read latch=0.
  - Filter shift registers cleared; FSM to IDLE.
  - Reset is released internally through a 2-flop synchroniser.
  - Reset mid-cycle aborts the cycle; no strobe is reissued after release.
- Filtering:
  - wr_s = ~(zwr_n|ziorq_n) and rd_s = ~(zrd_n|ziorq_n) are each shifted into a FILT-bit register every fclk.
  - Start condition: oldest bit 0, remaining FILT-1 bits all 1 (a rising edge stable for FILT-1 samples).
  - Glitches shorter than FILT-1 cycles never start a cycle.
- Start, accepted only in IDLE:
  - If any ch_req bit is set: capture the channel as the lowest-index set bit, baddr<=za, dir<=write?1:0.
  - On a write, also bd_out<=zd_in (registered capture, no transparent latch).
  - Write start has priority over a simultaneous read start.
  - A start with ch_req==0 is ignored; FSM stays IDLE.
  - Starts occurring outside IDLE are dropped, never queued.
- FSM states: IDLE -> SETUP -> STROBE -> HOLD -> IDLE.
  - SETUP lasts SETUP_CYC cycles; skipped when 0.
  - STROBE lasts STB_CYC cycles.
  - HOLD lasts HOLD_CYC cycles; skipped when 0.
  - A single down-counter, width sized for the maximum parameter, is reloaded at each state entry.
  - cs_n[ch]=0 in SETUP, STROBE and HOLD; all other cs_n stay 1.
  - brd_n/bwr_n (per dir) =0 only in STROBE.
  - bd_oe=1 in SETUP, STROBE and HOLD when dir=write.
  - All outputs are registered: cs_n falls the cycle after the start condition.
- Read latch: bd_in is captured on the last STROBE cycle (the clock edge where brd_n rises).
- Z80 side:
  - zd_oe = ~ziorq_n & ~zrd_n & |ch_req (combinational).
  - zd_out = read latch.
- Total cycle length = SETUP_CYC + STB_CYC + HOLD_CYC. The Z80 read must end after the latch edge; that timing is the integrator's responsibility.
- busy=1 from the cycle after the start through the last HOLD cycle.

Test Plan:
- Defaults, IOWR with ch_req=01, za=0x2AB, zd_in=0x5A held 10 cycles:
  - cs_n[0] low 6 cycles (1+4+1); bwr_n low 4 cycles starting 1 cycle after cs_n falls.
  - baddr=0x2AB, bd_out=0x5A, bd_oe high 6 cycles; cs_n[1] stays 1.
- Defaults, IORD ch_req=10, bd_in=0xC3 during the strobe:
  - cs_n[1] pulses; brd_n low 4 cycles; zd_out=0xC3 after brd_n rises.
  - zd_oe high exactly while IORQ&RD.
- Glitch: wr_s high for 1 cycle (FILT=3) -> no cs_n/bwr_n activity, busy stays 0.
- ch_req=11 on a write -> only cs_n[0] asserted. ch_req=00 -> no cycle at all.
- SETUP_CYC=0, HOLD_CYC=0, STB_CYC=1 -> cs_n and bwr_n low together for exactly 1 cycle.
- Second IOWR start during STROBE is dropped. zrst_n low mid-STROBE -> cs_n=all 1, bwr_n=1 immediately; no strobe after release.
